// File: rtl/fetch_arb_pkg.sv
// Shared constants and helpers for the fetch arbiter slice.
// Default geometry, requester-ID width and requester-ID type.
package fetch_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int A_S_DEF     = 8;
  localparam int D_S_DEF     = 32;
  localparam int MAX_OUT_DEF = 4;

  // Requester-ID width; a single requester still needs a 1-bit tag.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_w(N_REQ_DEF);

  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/fetch_arb_if.sv
// Requester, fetch-port and response bundle of the fetch arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface fetch_arb_if
  import fetch_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int A_S     = A_S_DEF,
  parameter int D_S     = D_S_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic [N_REQ-1:0]     req_vld;
  logic [N_REQ*A_S-1:0] req_addr;
  logic [N_REQ-1:0]     req_rdy;
  logic                 m_vld;
  logic [A_S-1:0]       m_addr;
  logic                 m_rdy;
  logic                 r_vld;
  logic [D_S-1:0]       r_pl;
  logic                 r_rdy;
  logic [N_REQ-1:0]     rsp_vld;
  logic [D_S-1:0]       rsp_pl;
  logic [N_REQ-1:0]     rsp_rdy;
  logic [CNT_W-1:0]     outstanding;
  logic                 err_orphan;

  modport slave (
    input  req_vld, req_addr, m_rdy, r_vld, r_pl, rsp_rdy,
    output req_rdy, m_vld, m_addr, r_rdy, rsp_vld, rsp_pl, outstanding, err_orphan
  );

  modport master (
    output req_vld, req_addr, m_rdy, r_vld, r_pl, rsp_rdy,
    input  req_rdy, m_vld, m_addr, r_rdy, rsp_vld, rsp_pl, outstanding, err_orphan
  );

endinterface

// File: rtl/fetch_tag_fifo.sv
// In-order tag FIFO holding the requester ID of each issued fetch.
// Pointers wrap naturally (DEPTH is a power of two); data array is not reset.
module fetch_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_arb.sv
// Round-robin arbiter sharing one in-order fetch port among N_REQ requesters.
// Issued requester IDs are queued so returning payloads steer back to their owner.
module fetch_arb
  import fetch_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int A_S     = A_S_DEF,
  parameter int D_S     = D_S_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic      clk,
  input  logic      rst,
  fetch_arb_if.slave bus
);
  localparam int IW    = id_w(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;
  localparam logic [IW:0]   N_REQ_W = (IW+1)'(N_REQ);
  localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);

  logic [IW-1:0]    rr_ptr, gnt_idx, head;
  logic [N_REQ-1:0] gnt;
  logic             gnt_any;
  logic [A_S-1:0]   addr_arr [N_REQ];
  logic             full, empty, push, pop;
  logic [CNT_W-1:0] count;
  logic             err_orphan_q;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin : grant
    logic [IW:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(k);
      if (idx >= N_REQ_W) idx = idx - N_REQ_W;
      if (!gnt_any && bus.req_vld[idx[IW-1:0]]) begin
        gnt_any              = 1'b1;
        gnt[idx[IW-1:0]]     = 1'b1;
        gnt_idx              = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_REQ; k++) addr_arr[k] = bus.req_addr[k*A_S +: A_S];
  end

  // Full is judged on the registered count only, so r_vld never reaches m_vld.
  assign bus.m_vld   = ~rst & gnt_any & ~full;
  assign bus.m_addr  = gnt_any ? addr_arr[gnt_idx] : '0;
  assign bus.req_rdy = (rst | full | ~bus.m_rdy) ? '0 : gnt;
  assign push        = bus.m_vld & bus.m_rdy;

  // With no tag outstanding a returning payload is drained as an orphan.
  assign bus.r_rdy   = ~rst & (empty ? bus.r_vld : bus.rsp_rdy[head]);
  assign pop         = bus.r_vld & bus.r_rdy & ~empty;

  always_comb begin
    bus.rsp_vld = '0;
    if (!rst && bus.r_vld && !empty) bus.rsp_vld[head] = 1'b1;
  end

  assign bus.rsp_pl      = D_S'(bus.r_pl);
  assign bus.outstanding = count;
  assign bus.err_orphan  = err_orphan_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      if (push) rr_ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
      if (bus.r_vld && empty) err_orphan_q <= 1'b1;
    end
  end

  fetch_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (IW)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (gnt_idx),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_arb.sv
// Directed bench for fetch_arb: arbitration order, full gating, response
// backpressure, orphan returns, async reset and concurrent push/pop.
module tb_fetch_arb;
  import fetch_arb_pkg::*;

  localparam int N_REQ   = 4;
  localparam int A_S     = 8;
  localparam int D_S     = 32;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_arb_if #(.N_REQ(N_REQ), .A_S(A_S), .D_S(D_S), .MAX_OUT(MAX_OUT)) bus ();

  fetch_arb #(.N_REQ(N_REQ), .A_S(A_S), .D_S(D_S), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev_id, prev_addr, exp_id;
    bit prev_v;

    bus.req_vld  = '0;
    bus.req_addr = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.m_rdy    = 1'b0;
    bus.r_vld    = 1'b0;
    bus.r_pl     = '0;
    bus.rsp_rdy  = '0;

    // reset values
    #2;
    chk("rst_m_vld",   32'(bus.m_vld),       0);
    chk("rst_req_rdy", 32'(bus.req_rdy),     0);
    chk("rst_r_rdy",   32'(bus.r_rdy),       0);
    chk("rst_rsp_vld", 32'(bus.rsp_vld),     0);
    chk("rst_out",     32'(bus.outstanding), 0);
    chk("rst_orphan",  32'(bus.err_orphan),  0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // round robin with a one-cycle-latency fetch port
    bus.req_vld = 4'hF;
    bus.m_rdy   = 1'b1;
    bus.rsp_rdy = 4'hF;
    prev_v = 1'b0; prev_id = 0; prev_addr = 0;
    for (int c = 0; c < 5; c++) begin
      exp_id     = c % 4;
      bus.r_vld  = prev_v;
      bus.r_pl   = 32'h4000_0000 + 32'(prev_addr);
      #1;
      chk("rr_addr", 32'(bus.m_addr),      (exp_id + 1) * 16);
      chk("rr_rdy",  32'(bus.req_rdy),     1 << exp_id);
      chk("rr_out",  32'(bus.outstanding), (c == 0) ? 0 : 1);
      if (prev_v) begin
        chk("rr_rsp_vld", 32'(bus.rsp_vld), 1 << prev_id);
        chk("rr_rsp_pl",  bus.rsp_pl,       32'h4000_0000 + 32'((prev_id + 1) * 16));
      end
      prev_id = exp_id; prev_addr = (exp_id + 1) * 16; prev_v = 1'b1;
      cyc();
    end
    bus.req_vld = '0;
    bus.r_vld   = 1'b1;
    bus.r_pl    = 32'h4000_0010;
    #1;
    chk("rr_last_vld", 32'(bus.rsp_vld), 32'h1);
    chk("rr_last_pl",  bus.rsp_pl,       32'h4000_0010);
    cyc();
    bus.r_vld = 1'b0;
    #1;
    chk("rr_drained", 32'(bus.outstanding), 0);

    // requester 2 streams into a port that never returns
    bus.req_vld = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_m_vld", 32'(bus.m_vld),       1);
      chk("full_out",   32'(bus.outstanding), i);
      cyc();
    end
    #1;
    chk("full_stall_vld", 32'(bus.m_vld),       0);
    chk("full_stall_rdy", 32'(bus.req_rdy),     0);
    chk("full_stall_out", 32'(bus.outstanding), 4);
    bus.r_vld = 1'b1;
    bus.r_pl  = 32'h4000_0030;
    #1;
    chk("full_pop_rsp",  32'(bus.rsp_vld), 32'h4);
    chk("full_pop_mvld", 32'(bus.m_vld),   0);
    cyc();
    bus.r_vld = 1'b0;
    #1;
    chk("full_after_out", 32'(bus.outstanding), 3);
    chk("full_after_vld", 32'(bus.m_vld),       1);
    chk("full_after_rdy", 32'(bus.req_rdy),     32'h4);
    cyc();
    bus.req_vld = '0;
    bus.r_vld   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_drain_rsp", 32'(bus.rsp_vld), 32'h4);
      cyc();
    end
    bus.r_vld = 1'b0;
    #1;
    chk("full_drain_out", 32'(bus.outstanding), 0);

    // response backpressure on requester 1 (rr_ptr is 3)
    bus.req_vld = 4'b0010;
    #1;
    chk("bp_grant", 32'(bus.req_rdy), 32'h2);
    cyc();
    bus.req_vld = '0;
    bus.r_vld   = 1'b1;
    bus.r_pl    = 32'hDEAD_BEEF;
    bus.rsp_rdy = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_r_rdy",   32'(bus.r_rdy),   0);
      chk("bp_rsp_vld", 32'(bus.rsp_vld), 32'h2);
      chk("bp_rsp_pl",  bus.rsp_pl,       32'hDEAD_BEEF);
      chk("bp_out",     32'(bus.outstanding), 1);
      cyc();
    end
    bus.rsp_rdy = 4'b0010;
    #1;
    chk("bp_rel_rdy", 32'(bus.r_rdy),   1);
    chk("bp_rel_vld", 32'(bus.rsp_vld), 32'h2);
    cyc();
    bus.r_vld   = 1'b0;
    bus.rsp_rdy = 4'hF;
    #1;
    chk("bp_out_done", 32'(bus.outstanding), 0);

    // concurrent push and pop at two outstanding (rr_ptr is 2)
    bus.req_vld = 4'b1001;
    #1;
    chk("pp_first", 32'(bus.m_addr), 32'h40);
    cyc();
    #1;
    chk("pp_second", 32'(bus.m_addr), 32'h10);
    cyc();
    bus.req_vld = 4'b0100;
    bus.r_vld   = 1'b1;
    bus.r_pl    = 32'h4000_0040;
    #1;
    chk("pp_out_pre", 32'(bus.outstanding), 2);
    chk("pp_head3",   32'(bus.rsp_vld),     32'h8);
    chk("pp_issue2",  32'(bus.req_rdy),     32'h4);
    cyc();
    bus.req_vld = '0;
    #1;
    chk("pp_out_hold", 32'(bus.outstanding), 2);
    chk("pp_head0",    32'(bus.rsp_vld),     32'h1);
    cyc();
    #1;
    chk("pp_head2", 32'(bus.rsp_vld),     32'h4);
    chk("pp_out1",  32'(bus.outstanding), 1);
    cyc();
    bus.r_vld = 1'b0;
    #1;
    chk("pp_out0", 32'(bus.outstanding), 0);

    // orphan return
    bus.r_vld = 1'b1;
    #1;
    chk("orph_r_rdy",  32'(bus.r_rdy),      1);
    chk("orph_rsp",    32'(bus.rsp_vld),    0);
    chk("orph_before", 32'(bus.err_orphan), 0);
    cyc();
    bus.r_vld = 1'b0;
    #1;
    chk("orph_set", 32'(bus.err_orphan),  1);
    chk("orph_out", 32'(bus.outstanding), 0);
    repeat (3) cyc();
    #1;
    chk("orph_sticky", 32'(bus.err_orphan), 1);

    // async reset mid-burst at three outstanding (rr_ptr is 3)
    bus.req_vld = 4'hF;
    repeat (3) cyc();
    #1;
    chk("mr_out3",  32'(bus.outstanding), 3);
    chk("mr_m_vld", 32'(bus.m_vld),       1);
    bus.r_vld   = 1'b1;
    bus.r_pl    = 32'h4000_0040;
    #1;
    chk("mr_r_rdy_pre", 32'(bus.r_rdy), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_m_vld_rst", 32'(bus.m_vld),       0);
    chk("mr_rdy_rst",   32'(bus.req_rdy),     0);
    chk("mr_r_rdy_rst", 32'(bus.r_rdy),       0);
    chk("mr_out_rst",   32'(bus.outstanding), 0);
    chk("mr_orph_rst",  32'(bus.err_orphan),  0);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.m_rdy = 1'b0;
    #1;
    chk("mr_ptr0",      32'(bus.m_addr),     32'h10);
    chk("mr_orph_rdy",  32'(bus.r_rdy),      1);
    chk("mr_orph_rsp",  32'(bus.rsp_vld),    0);
    cyc();
    bus.r_vld   = 1'b0;
    bus.req_vld = 4'b1000;
    bus.m_rdy   = 1'b1;
    #1;
    chk("mr_gnt3",     32'(bus.req_rdy),     32'h8);
    chk("mr_orph_set", 32'(bus.err_orphan),  1);
    chk("mr_out_rel",  32'(bus.outstanding), 0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
